jpeg_frame_sequencer: RTL
=========================

// Module: jpeg_frame_sequencer
// PURPOSE
//  Sequences one JPEG file per start pulse onto an 8-bit AXI-Stream byte output: header ROM bytes,
//  then entropy-coded scan bytes with 0xFF->0xFF,0x00 stuffing, then the EOI marker 0xFF,0xD9.
//  Sits between the entropy coder's byte stream and the file/DMA sink.
//  Owns the header ROM read port and is the only driver of the output stream.
// PARAMETERS
//  HEADER_SIZE  623  number of header bytes read from ROM (addresses 0..HEADER_SIZE-1), must be >=1
//  HDR_AW       10   header ROM address width, 2**HDR_AW >= HEADER_SIZE
//  STUFF_EN     1    1: insert 0x00 after every scan byte equal to 0xFF; 0: pass scan bytes unchanged
// PORTS
//  clk            in   1       clock, all logic rising-edge
//  rst            in   1       synchronous, active-high reset
//  start          in   1       1-cycle pulse, begins a frame; ignored unless state==IDLE
//  busy           out  1       1 in any state other than IDLE
//  frame_done     out  1       1-cycle pulse on the cycle the EOI 0xD9 byte handshakes
//  frame_bytes    out  32      bytes emitted in current/last frame (incl. stuffing and EOI)
//  hdr_addr       out  HDR_AW  header ROM address
//  hdr_data       in   8       header ROM data, combinational from hdr_addr
//  s_axis_tdata   in   8       scan byte
//  s_axis_tvalid  in   1       scan byte valid
//  s_axis_tready  out  1       scan byte accepted when tvalid&tready
//  s_axis_tlast   in   1       last scan byte of the frame
//  m_axis_tdata   out  8       output byte
//  m_axis_tvalid  out  1       output valid
//  m_axis_tready  in   1       sink ready
//  m_axis_tlast   out  1       1 only on EOI 0xD9
//  m_axis_tuser   out  1       1 only on first header byte (start of file)
// BEHAVIOUR
//  Reset: state=IDLE; m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0, s_axis_tready=0, busy=0,
//   frame_done=0, frame_bytes=0, hdr_addr=0. Reset mid-frame abandons the frame; no EOI is emitted.
//  Output stage: one register. Loads a new byte when !m_axis_tvalid || m_axis_tready; else holds
//   tdata/tlast/tuser stable (AXIS rule). tvalid never drops without a handshake.
//  States: IDLE -> HDR -> SCAN -> (STUFF) -> EOI_FF -> EOI_D9 -> IDLE.
//  IDLE: start -> HDR, hdr_addr=0, frame_bytes=0.
//  HDR: on load, emit hdr_data, hdr_addr+1; tuser=1 when hdr_addr==0. After loading address
//   HEADER_SIZE-1 -> SCAN.
//  SCAN: s_axis_tready = output stage can load. Accepted byte goes to output the same edge
//   (1-cycle latency in->out). If STUFF_EN && byte==0xFF -> STUFF (tlast remembered);
//   else tlast -> EOI_FF; else stay.
//  STUFF: s_axis_tready=0; on load emit 0x00, then -> EOI_FF if remembered tlast else SCAN.
//  EOI_FF: on load emit 0xFF -> EOI_D9. EOI_D9: on load emit 0xD9 with tlast=1 -> IDLE.
//  frame_done pulses on the handshake of the 0xD9 byte (state is IDLE by then); busy stays 1
//   until that handshake. start received while busy is dropped, not queued.
//  frame_bytes increments by 1 on every output handshake; 32-bit wrap is permitted.
//  s_axis_tready=0 in all states other than SCAN. Scan byte 0xFF with tlast: emit 0xFF,0x00,0xFF,0xD9.
//  Empty scan not supported: SCAN waits for at least one byte carrying tlast.
// TESTING
//  1 HEADER_SIZE=4 ROM={FF,D8,FF,E0}, scan {12,34 last}, ready=1 -> FF D8 FF E0 12 34 FF D9;
//    tuser on byte0 only, tlast on D9, frame_done 1 cycle, frame_bytes=8.
//  2 Scan {FF,01 last}, STUFF_EN=1 -> ...FF 00 01 FF D9; with STUFF_EN=0 -> ...FF 01 FF D9.
//  3 Scan {AB,FF last} -> ...AB FF 00 FF D9; s_axis_tready=0 during stuff byte.
//  4 m_axis_tready random 50% -> identical byte sequence; tdata stable while valid&!ready.
//  5 start pulsed during SCAN -> ignored; second start after frame_done -> full second frame,
//    frame_bytes restarts at 0.
//  6 rst asserted mid-HDR -> next cycle all outputs at reset values; new start -> clean frame from addr 0.

Source files
------------

// File: rtl/jpeg_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// jpeg_frame_sequencer_if
//   8-bit AXI-Stream byte channel used on both sides of the JPEG frame
//   sequencer.
//   Signals:
//     tdata  [7:0]  byte payload
//     tvalid        source has a byte
//     tready        sink accepts the byte (transfer on tvalid & tready)
//     tlast         last byte of a frame/scan
//     tuser         start-of-file marker (driven by the sequencer output only)
//   Modports:
//     master  drives tdata/tvalid/tlast/tuser, samples tready
//     slave   samples tdata/tvalid/tlast, drives tready (the scan input
//             carries no tuser)
// ---------------------------------------------------------------------------
interface jpeg_frame_sequencer_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/jpeg_frame_sequencer.sv
// ---------------------------------------------------------------------------
// jpeg_frame_sequencer
//   Emits one complete JPEG file per start pulse on an 8-bit AXI-Stream:
//   header bytes read from an external ROM, then the entropy-coded scan bytes
//   (with 0xFF -> 0xFF,0x00 byte stuffing when STUFF_EN=1), then the EOI
//   marker 0xFF,0xD9.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start             frame start pulse, dropped while busy
//     busy              frame in progress (until the 0xD9 byte handshakes)
//     frame_done        pulse on the 0xD9 output handshake
//     frame_bytes[31:0] bytes emitted in current/last frame
//     hdr_addr/hdr_data header ROM read port (combinational ROM)
//     s_axis            scan byte input (slave)
//     m_axis            file byte output (master), tuser = first byte,
//                       tlast = EOI 0xD9
// ---------------------------------------------------------------------------
module jpeg_frame_sequencer #(
   parameter int unsigned HEADER_SIZE = 623,
   parameter int unsigned HDR_AW      = 10,
   parameter bit          STUFF_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  frame_done,
   output logic [31:0]           frame_bytes,
   output logic [HDR_AW-1:0]     hdr_addr,
   input  logic [7:0]            hdr_data,
   jpeg_frame_sequencer_if.slave  s_axis,
   jpeg_frame_sequencer_if.master m_axis
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_SCAN,
      ST_STUFF,
      ST_EOI_FF,
      ST_EOI_D9
   } state_e;

   localparam logic [HDR_AW-1:0] HDR_LAST = HDR_AW'(HEADER_SIZE - 1);

   state_e            state_q;
   logic [HDR_AW-1:0] hdr_addr_q;
   logic [31:0]       frame_bytes_q;
   logic [7:0]        tdata_q;
   logic              tvalid_q;
   logic              tlast_q;
   logic              tuser_q;
   logic              last_seen_q;   // tlast of a scan 0xFF awaiting its stuff byte

   logic load;      // output register may take a new byte this cycle
   logic out_hs;    // output handshake
   logic scan_hs;   // scan input handshake

   assign load    = !tvalid_q || m_axis.tready;
   assign out_hs  = tvalid_q && m_axis.tready;
   // The scan byte goes straight into the output register, so the input is
   // ready exactly when that register can load.
   assign s_axis.tready = (state_q == ST_SCAN) && load;
   assign scan_hs       = s_axis.tvalid && s_axis.tready;

   // The 0xD9 byte is loaded as the FSM returns to IDLE; the frame is still
   // in flight until that byte is taken by the sink.
   assign busy       = (state_q != ST_IDLE) || (tvalid_q && tlast_q);
   assign frame_done = out_hs && tlast_q;

   assign frame_bytes   = frame_bytes_q;
   assign hdr_addr      = hdr_addr_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tuser  = tuser_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // branch below sees the pre-edge register values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         hdr_addr_q    <= '0;
         frame_bytes_q <= '0;
         tdata_q       <= '0;
         tvalid_q      <= 1'b0;
         tlast_q       <= 1'b0;
         tuser_q       <= 1'b0;
         last_seen_q   <= 1'b0;
      end else begin
         if (out_hs) begin
            frame_bytes_q <= frame_bytes_q + 32'd1;
         end
         // Whenever the register can load but no state below supplies a
         // byte, it empties; tvalid therefore only falls after a handshake.
         if (load) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (start && !busy) begin
                  state_q       <= ST_HDR;
                  hdr_addr_q    <= '0;
                  frame_bytes_q <= '0;
               end
            end
            ST_HDR: begin
               if (load) begin
                  tdata_q    <= hdr_data;
                  tvalid_q   <= 1'b1;
                  tuser_q    <= (hdr_addr_q == '0);
                  hdr_addr_q <= hdr_addr_q + 1'b1;
                  if (hdr_addr_q == HDR_LAST) begin
                     state_q <= ST_SCAN;
                  end
               end
            end
            ST_SCAN: begin
               if (scan_hs) begin
                  tdata_q  <= s_axis.tdata;
                  tvalid_q <= 1'b1;
                  if (STUFF_EN && (s_axis.tdata == 8'hFF)) begin
                     state_q     <= ST_STUFF;
                     last_seen_q <= s_axis.tlast;
                  end else if (s_axis.tlast) begin
                     state_q <= ST_EOI_FF;
                  end
               end
            end
            ST_STUFF: begin
               if (load) begin
                  tdata_q  <= 8'h00;
                  tvalid_q <= 1'b1;
                  state_q  <= last_seen_q ? ST_EOI_FF : ST_SCAN;
               end
            end
            ST_EOI_FF: begin
               if (load) begin
                  tdata_q  <= 8'hFF;
                  tvalid_q <= 1'b1;
                  state_q  <= ST_EOI_D9;
               end
            end
            ST_EOI_D9: begin
               if (load) begin
                  tdata_q  <= 8'hD9;
                  tvalid_q <= 1'b1;
                  tlast_q  <= 1'b1;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
